// File: rtl/if_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared CPU definitions for the instruction fetch front end.
//   XLEN           : datapath / address width
//   PC_STEP        : sequential fetch increment in bytes
//   fetch_state_t  : fetch FSM states (IDLE, FETCH)
//   fetch_entry_t  : one queued instruction together with its PC
//   align_pc()     : forces a byte address onto a word boundary
// ----------------------------------------------------------------------------
package if_fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Circular buffer holding fetched {pc, instr} entries for the decode stage.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   push, data : write one entry (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   head       : current head entry
//   count      : number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the top masks the head while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
// Instruction fetch unit: issues sequential reads to instruction memory and
// queues the returned instructions with their PCs for decode.
// Parameters: DEPTH (queue entries, power of two), RESET_PC (first fetch PC).
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : fetch enable
//   redirect_i/_pc_i      : branch/jump redirect pulse and target
//   imem_req_o/_addr_o    : instruction memory read strobe and byte address
//   imem_instr_i          : read data, one cycle after the strobe
//   valid_o/ready_i       : head handshake towards decode
//   instr_o/pc_o          : head instruction and its PC
// Optional build macro IF_STARVE_CNT_EN adds starve_cnt_o, counting FETCH
// cycles in which decode has nothing to consume.
// ----------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
`ifdef IF_STARVE_CNT_EN
    ,
    output logic [31:0] starve_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            squash;
    logic            req;
    logic            push;
    logic            pop;
    logic            credit_ok;
    logic [CNT_W:0]  credits_used;
    logic [CNT_W-1:0] count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // Queued entries plus the outstanding read must leave room for one more,
    // so a returning response always has a free slot.
    assign credits_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign credit_ok    = 32'(credits_used) < 32'(DEPTH);

    // A response arriving in a redirect cycle belongs to the old path.
    assign squash     = redirect_i && inflight;
    assign push       = inflight && !squash;
    assign push_entry = '{pc: inflight_pc, instr: imem_instr_i};

    assign valid_o = (count != '0) && !rst_i;
    assign pop     = valid_o && ready_i && !redirect_i;
    assign instr_o = valid_o ? head.instr : '0;
    assign pc_o    = valid_o ? head.pc : '0;

    assign imem_req_o  = req;
    assign imem_addr_o = rst_i ? RESET_PC : fetch_pc;

    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!start_i) begin
                    state_next = ST_IDLE;
                end
                req = start_i && credit_ok && !redirect_i;
            end
            default: state_next = ST_IDLE;
        endcase
        if (rst_i) begin
            req = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            inflight <= req;
            if (redirect_i) begin
                fetch_pc <= align_pc(redirect_pc_i);
            end else if (req) begin
                fetch_pc    <= fetch_pc + PC_STEP;
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .data  (push_entry),
        .pop   (pop),
        .flush (redirect_i),
        .head  (head),
        .count (count)
    );

`ifdef IF_STARVE_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_o <= '0;
        end else if ((state == ST_FETCH) && !valid_o && !redirect_i) begin
            starve_cnt_o <= starve_cnt_o + 32'd1;
        end
    end
`endif

endmodule
